// File: rtl/nxn_rr_wormhole_crossbar.sv
// Registered IN_N x OUT_M wormhole crossbar with per-output round-robin
// arbitration, head-to-tail output locking and a one-stage output register.
module nxn_rr_wormhole_crossbar #(
   parameter int  DATA_W = 10,
   parameter int  IN_N   = 5,
   parameter int  OUT_M  = 5,
   localparam int DST_W  = $clog2(OUT_M)
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [IN_N*DATA_W-1:0]  data_i,
   input  logic [IN_N-1:0]         valid_i,
   output logic [IN_N-1:0]         ready_o,
   input  logic [IN_N*DST_W-1:0]   dst_i,
   output logic [OUT_M*DATA_W-1:0] data_o,
   output logic [OUT_M-1:0]        valid_o,
   input  logic [OUT_M-1:0]        ready_i,
   output logic [IN_N-1:0]         drop_o
);

   localparam int SEL_W = $clog2(IN_N);

   typedef enum logic {ST_IDLE, ST_LOCKED} state_t;
   typedef enum logic [1:0] {
      FLIT_BODY   = 2'b00,
      FLIT_HEAD   = 2'b01,
      FLIT_TAIL   = 2'b10,
      FLIT_SINGLE = 2'b11
   } flit_id_t;

   logic [DATA_W-1:0]       w_flit [IN_N];
   flit_id_t                w_id   [IN_N];
   logic [DST_W-1:0]        w_dst  [IN_N];
   logic [IN_N-1:0]         w_opens;
   logic [IN_N-1:0]         w_dst_ok;
   logic [IN_N-1:0]         w_owns;
   logic [IN_N-1:0]         w_drop;
   logic [IN_N-1:0]         w_ready;

   state_t                  r_state     [OUT_M];
   state_t                  w_state_nxt [OUT_M];
   logic [SEL_W-1:0]        r_owner     [OUT_M];
   logic [SEL_W-1:0]        w_owner_nxt [OUT_M];
   logic [SEL_W-1:0]        r_ptr       [OUT_M];
   logic [SEL_W-1:0]        w_ptr_nxt   [OUT_M];
   logic [SEL_W-1:0]        w_sel       [OUT_M];
   logic [OUT_M-1:0]        w_can_load;
   logic [OUT_M-1:0]        w_xfer;
   logic                    w_found;
   logic [SEL_W-1:0]        w_idx;

   logic [OUT_M-1:0]        r_valid;
   logic [OUT_M*DATA_W-1:0] r_data;
   logic [IN_N-1:0]         r_drop;

   // Per-input decode: flit fields, ownership of any locked output, drop detection
   always_comb begin
      w_owns = '0;
      for (int unsigned i = 0; i < IN_N; i++) begin
         w_flit[i]   = data_i[i*DATA_W +: DATA_W];
         w_id[i]     = flit_id_t'(data_i[i*DATA_W+DATA_W-2 +: 2]);
         w_dst[i]    = dst_i[i*DST_W +: DST_W];
         w_opens[i]  = (w_id[i] == FLIT_HEAD) || (w_id[i] == FLIT_SINGLE);
         w_dst_ok[i] = {1'b0, w_dst[i]} < (DST_W+1)'(OUT_M);
         for (int unsigned j = 0; j < OUT_M; j++) begin
            if ((r_state[j] == ST_LOCKED) && (r_owner[j] == SEL_W'(i))) w_owns[i] = 1'b1;
         end
         // an owner's head is forwarded on its locked output, never dropped
         w_drop[i] = valid_i[i] & w_opens[i] & ~w_owns[i] & ~w_dst_ok[i];
      end
   end

   // Per-output round-robin arbitration and wormhole lock next-state
   always_comb begin
      w_found = 1'b0;
      w_idx   = '0;
      for (int unsigned j = 0; j < OUT_M; j++) begin
         w_state_nxt[j] = r_state[j];
         w_owner_nxt[j] = r_owner[j];
         w_ptr_nxt[j]   = r_ptr[j];
         w_sel[j]       = r_owner[j];
         w_xfer[j]      = 1'b0;
         w_can_load[j]  = ~r_valid[j] | ready_i[j];
         w_found        = 1'b0;
         if (r_state[j] == ST_IDLE) begin
            // search ptr+1 .. ptr+IN_N so the last winner has lowest priority
            for (int unsigned k = 1; k <= IN_N; k++) begin
               w_idx = SEL_W'((32'(r_ptr[j]) + k) % IN_N);
               if (!w_found && valid_i[w_idx] && w_opens[w_idx] && !w_owns[w_idx] &&
                   (w_dst[w_idx] == DST_W'(j))) begin
                  w_found  = 1'b1;
                  w_sel[j] = w_idx;
               end
            end
            if (w_found && w_can_load[j]) begin
               w_xfer[j]    = 1'b1;
               w_ptr_nxt[j] = w_sel[j];
               if (w_id[w_sel[j]] == FLIT_HEAD) begin
                  w_state_nxt[j] = ST_LOCKED;
                  w_owner_nxt[j] = w_sel[j];
               end
            end
         end else begin
            if (valid_i[r_owner[j]] && w_can_load[j]) begin
               w_xfer[j] = 1'b1;
               if (w_id[r_owner[j]] == FLIT_TAIL) w_state_nxt[j] = ST_IDLE;
            end
         end
      end
   end

   // Input handshake: accepted when forwarded to an output or dropped
   always_comb begin
      w_ready = w_drop;
      for (int unsigned j = 0; j < OUT_M; j++) begin
         if (w_xfer[j]) w_ready[w_sel[j]] = 1'b1;
      end
   end

   assign ready_o = rst_i ? '0 : w_ready;
   assign valid_o = r_valid;
   assign data_o  = r_data;
   assign drop_o  = r_drop;

   // Output FSM state, lock owner and round-robin pointer registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int unsigned j = 0; j < OUT_M; j++) begin
            r_state[j] <= ST_IDLE;
            r_owner[j] <= '0;
            r_ptr[j]   <= '0;
         end
      end else begin
         for (int unsigned j = 0; j < OUT_M; j++) begin
            r_state[j] <= w_state_nxt[j];
            r_owner[j] <= w_owner_nxt[j];
            r_ptr[j]   <= w_ptr_nxt[j];
         end
      end
   end

   // Output flit registers and registered drop pulse
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_valid <= '0;
         r_data  <= '0;
         r_drop  <= '0;
      end else begin
         r_drop <= w_drop;
         for (int unsigned j = 0; j < OUT_M; j++) begin
            if (w_xfer[j]) begin
               r_valid[j]                    <= 1'b1;
               r_data[j*DATA_W +: DATA_W]    <= w_flit[w_sel[j]];
            end else if (ready_i[j]) begin
               r_valid[j] <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_nxn_rr_wormhole_crossbar.sv
// Directed, table-driven bench for the wormhole crossbar (5x5, 10-bit flits).
module tb_nxn_rr_wormhole_crossbar;

   localparam int DATA_W = 10;
   localparam int IN_N   = 5;
   localparam int OUT_M  = 5;
   localparam int DST_W  = 3;

   logic                    clk_i = 1'b0;
   logic                    rst_i;
   logic [IN_N*DATA_W-1:0]  data_i;
   logic [IN_N-1:0]         valid_i;
   logic [IN_N-1:0]         ready_o;
   logic [IN_N*DST_W-1:0]   dst_i;
   logic [OUT_M*DATA_W-1:0] data_o;
   logic [OUT_M-1:0]        valid_o;
   logic [OUT_M-1:0]        ready_i;
   logic [IN_N-1:0]         drop_o;

   int n_err = 0;
   int n_chk = 0;

   nxn_rr_wormhole_crossbar #(
      .DATA_W (DATA_W),
      .IN_N   (IN_N),
      .OUT_M  (OUT_M)
   ) dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .data_i  (data_i),
      .valid_i (valid_i),
      .ready_o (ready_o),
      .dst_i   (dst_i),
      .data_o  (data_o),
      .valid_o (valid_o),
      .ready_i (ready_i),
      .drop_o  (drop_o)
   );

   always #5 clk_i = ~clk_i;

   // one cycle of stimulus plus the expected comb ready and post-edge outputs
   typedef struct packed {
      logic [4:0]  vld;
      logic [49:0] dat;
      logic [14:0] dst;
      logic [4:0]  rdy;
      logic [4:0]  e_rdy;
      logic [4:0]  e_vo;
      logic [49:0] e_do;
      logic [4:0]  e_drop;
   } vec_t;

   vec_t tbl[$];

   localparam logic [4:0] ALL = 5'b11111;

   function automatic logic [49:0] fl(input int ch, input logic [9:0] f);
      logic [49:0] r;
      r = '0;
      r[ch*10 +: 10] = f;
      return r;
   endfunction

   function automatic logic [14:0] dd(input int ch, input int d);
      logic [14:0] r;
      r = '0;
      r[ch*3 +: 3] = 3'(d);
      return r;
   endfunction

   function automatic vec_t mk(input logic [4:0] vld, input logic [49:0] dat,
                               input logic [14:0] dst, input logic [4:0] rdy,
                               input logic [4:0] e_rdy, input logic [4:0] e_vo,
                               input logic [49:0] e_do, input logic [4:0] e_drop);
      vec_t v;
      v.vld = vld; v.dat = dat; v.dst = dst; v.rdy = rdy;
      v.e_rdy = e_rdy; v.e_vo = e_vo; v.e_do = e_do; v.e_drop = e_drop;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic apply(input vec_t v, input string tag);
      logic [49:0] m;
      valid_i = v.vld;
      data_i  = v.dat;
      dst_i   = v.dst;
      ready_i = v.rdy;
      #3;
      check({tag, ".ready_o"}, 64'(ready_o), 64'(v.e_rdy));
      @(posedge clk_i);
      #1;
      check({tag, ".valid_o"}, 64'(valid_o), 64'(v.e_vo));
      check({tag, ".drop_o"}, 64'(drop_o), 64'(v.e_drop));
      if (v.e_vo != '0) begin
         m = '0;
         for (int j = 0; j < 5; j++) if (v.e_vo[j]) m[j*10 +: 10] = '1;
         check({tag, ".data_o"}, 64'(data_o & m), 64'(v.e_do & m));
      end
   endtask

   initial begin
      vec_t idle;
      logic [49:0] d3;
      idle = mk('0, '0, '0, ALL, '0, '0, '0, '0);

      // single flit
      tbl.push_back(mk(5'b00001, fl(0,10'h3AA), dd(0,2), ALL, 5'b00001, 5'b00100, fl(2,10'h3AA), '0));
      tbl.push_back(idle);
      // parallel packets in0->out1, in3->out4
      tbl.push_back(mk(5'b01001, fl(0,10'h101)|fl(3,10'h111), dd(0,1)|dd(3,4), ALL,
                       5'b01001, 5'b10010, fl(1,10'h101)|fl(4,10'h111), '0));
      tbl.push_back(mk(5'b01001, fl(0,10'h002)|fl(3,10'h012), dd(0,1)|dd(3,4), ALL,
                       5'b01001, 5'b10010, fl(1,10'h002)|fl(4,10'h012), '0));
      tbl.push_back(mk(5'b01001, fl(0,10'h203)|fl(3,10'h213), dd(0,1)|dd(3,4), ALL,
                       5'b01001, 5'b10010, fl(1,10'h203)|fl(4,10'h213), '0));
      tbl.push_back(idle);
      // contention on out0: in1, in2, in4 singles held valid
      d3 = fl(1,10'h3C1) | fl(2,10'h3C2) | fl(4,10'h3C4);
      tbl.push_back(mk(5'b10110, d3, '0, ALL, 5'b00010, 5'b00001, fl(0,10'h3C1), '0));
      tbl.push_back(mk(5'b10110, d3, '0, ALL, 5'b00100, 5'b00001, fl(0,10'h3C2), '0));
      tbl.push_back(mk(5'b10110, d3, '0, ALL, 5'b10000, 5'b00001, fl(0,10'h3C4), '0));
      tbl.push_back(mk(5'b10110, d3, '0, ALL, 5'b00010, 5'b00001, fl(0,10'h3C1), '0));
      tbl.push_back(idle);

      // reset with a head pending on in0: nothing accepted while reset is high
      rst_i   = 1'b1;
      valid_i = 5'b00001;
      data_i  = fl(0,10'h101);
      dst_i   = '0;
      ready_i = ALL;
      repeat (2) @(posedge clk_i);
      #1;
      check("reset.valid_o", 64'(valid_o), 64'(0));
      check("reset.data_o", 64'(data_o), 64'(0));
      check("reset.ready_o", 64'(ready_o), 64'(0));
      check("reset.drop_o", 64'(drop_o), 64'(0));
      valid_i = '0;
      data_i  = '0;
      rst_i   = 1'b0;

      foreach (tbl[n]) apply(tbl[n], $sformatf("tbl%0d", n));

      // wormhole lock: in2 owns out3, in0 head waits until after in2's tail
      apply(mk(5'b00100, fl(2,10'h120), dd(2,3), ALL, 5'b00100, 5'b01000, fl(3,10'h120), '0), "lock.h");
      apply(mk(5'b00101, fl(2,10'h021)|fl(0,10'h130), dd(2,3)|dd(0,3), ALL,
               5'b00100, 5'b01000, fl(3,10'h021), '0), "lock.b1");
      apply(mk(5'b00101, fl(2,10'h023)|fl(0,10'h130), dd(2,3)|dd(0,3), ALL,
               5'b00100, 5'b01000, fl(3,10'h023), '0), "lock.b2");
      apply(mk(5'b00101, fl(2,10'h222)|fl(0,10'h130), dd(2,3)|dd(0,3), ALL,
               5'b00100, 5'b01000, fl(3,10'h222), '0), "lock.t");
      apply(mk(5'b00001, fl(0,10'h130), dd(0,3), ALL, 5'b00001, 5'b01000, fl(3,10'h130), '0), "lock.new");
      apply(mk(5'b00001, fl(0,10'h231), dd(0,3), ALL, 5'b00001, 5'b01000, fl(3,10'h231), '0), "lock.newt");
      apply(idle, "lock.idle");

      // backpressure on out1 during a 4-flit packet from in1
      apply(mk(5'b00010, fl(1,10'h141), dd(1,1), ALL, 5'b00010, 5'b00010, fl(1,10'h141), '0), "bp.h");
      for (int s = 0; s < 4; s++)
         apply(mk(5'b00010, fl(1,10'h042), dd(1,1), 5'b11101, '0, 5'b00010, fl(1,10'h141), '0),
               $sformatf("bp.stall%0d", s));
      apply(mk(5'b00010, fl(1,10'h042), dd(1,1), ALL, 5'b00010, 5'b00010, fl(1,10'h042), '0), "bp.b1");
      apply(mk(5'b00010, fl(1,10'h043), dd(1,1), ALL, 5'b00010, 5'b00010, fl(1,10'h043), '0), "bp.b2");
      apply(mk(5'b00010, fl(1,10'h244), dd(1,1), ALL, 5'b00010, 5'b00010, fl(1,10'h244), '0), "bp.t");
      apply(idle, "bp.idle");

      // drop on out-of-range destination
      apply(mk(5'b00001, fl(0,10'h150), dd(0,6), ALL, 5'b00001, '0, '0, 5'b00001), "drop");
      apply(idle, "drop.idle");

      // reset mid-packet, then a fresh head wins while the orphaned body stalls
      apply(mk(5'b01000, fl(3,10'h160), dd(3,2), ALL, 5'b01000, 5'b00100, fl(2,10'h160), '0), "mid.h");
      valid_i = 5'b01000;
      data_i  = fl(3,10'h061);
      #2;
      rst_i = 1'b1;
      #1;
      check("mid.rst.valid_o", 64'(valid_o), 64'(0));
      check("mid.rst.data_o", 64'(data_o), 64'(0));
      check("mid.rst.ready_o", 64'(ready_o), 64'(0));
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      apply(mk(5'b11000, fl(3,10'h061)|fl(4,10'h170), dd(3,2)|dd(4,2), ALL,
               5'b10000, 5'b00100, fl(2,10'h170), '0), "mid.new");
      apply(mk(5'b11000, fl(3,10'h061)|fl(4,10'h271), dd(3,2)|dd(4,2), ALL,
               5'b10000, 5'b00100, fl(2,10'h271), '0), "mid.newt");
      apply(idle, "mid.idle");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
